// File: rtl/memory_access.sv
// RV32I load/store stage between execute and writeback: one outstanding data-memory
// transaction, byte-lane steering for stores and sign/zero extension for loads.
module memory_access #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              memren_i,
    input  logic              memwen_i,
    input  logic [2:0]        funct3_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [AWIDTH-1:0] dmem_addr_o,
    output logic [DWIDTH-1:0] dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_ack_i,
    input  logic [DWIDTH-1:0] dmem_rdata_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DWIDTH-1:0] memory_data_o,
    output logic              error_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Illegal size code, conflicting direction or misalignment for the access size.
    function automatic logic access_error(input logic ren, input logic wen,
                                          input logic [2:0] f3, input logic [1:0] lo);
        logic err;
        err = 1'b0;
        if (ren && wen) begin
            err = 1'b1;
        end else if (ren) begin
            case (f3)
                3'b000, 3'b100: err = 1'b0;
                3'b001, 3'b101: err = lo[0];
                3'b010:         err = (lo != 2'b00);
                default:        err = 1'b1;
            endcase
        end else if (wen) begin
            case (f3)
                3'b000:  err = 1'b0;
                3'b001:  err = lo[0];
                3'b010:  err = (lo != 2'b00);
                default: err = 1'b1;
            endcase
        end else begin
            err = 1'b0;
        end
        return err;
    endfunction

    function automatic logic [3:0] lane_enable(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{w[7:0]}};
            2'b01:   r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    // Shift the addressed lane down to bit 0, then extend according to funct3.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rd >> {lo, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b100:  r = {24'h00_0000, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            3'b010:  r = rd;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    logic [1:0] state_r;
    logic [1:0] addr_lo_r;
    logic [2:0] funct3_r;
    logic       memren_r;
    logic       memwen_r;
    logic       accept_s;
    logic       mem_op_s;
    logic       err_s;

    assign ready_o  = (state_r == IDLE);
    assign accept_s = valid_i && ready_o;
    assign mem_op_s = memren_i || memwen_i;
    assign err_s    = access_error(memren_i, memwen_i, funct3_i, addr_i[1:0]);

    // Transaction FSM with all stage outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            addr_lo_r     <= 2'b00;
            funct3_r      <= 3'b000;
            memren_r      <= 1'b0;
            memwen_r      <= 1'b0;
            dmem_req_o    <= 1'b0;
            dmem_we_o     <= 1'b0;
            dmem_addr_o   <= '0;
            dmem_wdata_o  <= '0;
            dmem_be_o     <= 4'b0000;
            valid_o       <= 1'b0;
            memory_data_o <= '0;
            error_o       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_lo_r <= addr_i[1:0];
                        funct3_r  <= funct3_i;
                        memren_r  <= memren_i;
                        memwen_r  <= memwen_i;
                        if (mem_op_s && !err_s) begin
                            state_r      <= REQ;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= memwen_i;
                            dmem_addr_o  <= {addr_i[AWIDTH-1:2], 2'b00};
                            dmem_wdata_o <= memwen_i ? replicate(funct3_i, wdata_i) : '0;
                            dmem_be_o    <= lane_enable(funct3_i, addr_i[1:0]);
                        end else begin
                            // Non-memory ops and rejected accesses answer without a bus cycle.
                            state_r       <= RESP;
                            valid_o       <= 1'b1;
                            error_o       <= err_s;
                            memory_data_o <= '0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (dmem_ack_i) begin
                        state_r       <= RESP;
                        dmem_req_o    <= 1'b0;
                        dmem_we_o     <= 1'b0;
                        dmem_be_o     <= 4'b0000;
                        valid_o       <= 1'b1;
                        error_o       <= 1'b0;
                        memory_data_o <= (memren_r && !memwen_r)
                                         ? load_extend(funct3_r, addr_lo_r, dmem_rdata_i) : '0;
                    end else begin
                        state_r <= REQ;
                    end
                end
                RESP: begin
                    if (ready_i) begin
                        state_r       <= IDLE;
                        valid_o       <= 1'b0;
                        error_o       <= 1'b0;
                        memory_data_o <= '0;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    dmem_req_o <= 1'b0;
                    dmem_we_o  <= 1'b0;
                    dmem_be_o  <= 4'b0000;
                    valid_o    <= 1'b0;
                    error_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed table vectors plus randomized transactions against an arithmetic reference model.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        memren_i = 1'b0;
    logic        memwen_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'h0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] memory_data_o;
    logic        error_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_access #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .memren_i(memren_i), .memwen_i(memwen_i),
        .funct3_i(funct3_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
        .ready_i(ready_i), .memory_data_o(memory_data_o), .error_o(error_o)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        int          rdy_dly;
        logic        e_err;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_addr;
        logic [31:0] e_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: access size in bytes, alignment by modulo, lanes by arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        int     size;
        int     off;
        bit     sgn;
        bit     legal;
        longint val;
        longint mask;
        r = v;
        r.e_err = 1'b0; r.e_req = 1'b0; r.e_we = 1'b0; r.e_be = 4'b0000;
        r.e_wdata = 32'h0; r.e_addr = 32'h0; r.e_data = 32'h0;
        size = 0; sgn = 1'b0; legal = 1'b1;
        off = int'(v.addr % 32'd4);
        if (v.ren && v.wen) begin
            legal = 1'b0;
        end else if (v.ren) begin
            case (int'(v.f3))
                0: begin size = 1; sgn = 1'b1; end
                4: size = 1;
                1: begin size = 2; sgn = 1'b1; end
                5: size = 2;
                2: size = 4;
                default: legal = 1'b0;
            endcase
        end else if (v.wen) begin
            case (int'(v.f3))
                0: size = 1;
                1: size = 2;
                2: size = 4;
                default: legal = 1'b0;
            endcase
        end
        if (!v.ren && !v.wen) return r;
        if (!legal || (off % size) != 0) begin
            r.e_err = 1'b1;
            return r;
        end
        r.e_req  = 1'b1;
        r.e_we   = v.wen;
        r.e_addr = v.addr - 32'(off);
        r.e_be   = 4'(((1 << size) - 1) << off);
        for (int j = 0; j < 4; j++) r.e_wdata[8*j +: 8] = v.wdata[8*(j % size) +: 8];
        if (v.ren) begin
            val  = longint'(v.rdata) >> (8 * off);
            mask = (longint'(1) << (8 * size)) - 1;
            val  = val & mask;
            if (sgn && val[8*size-1]) val = val | ~mask;
            r.e_data = val[31:0];
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] held;
        @(negedge clk);
        chk({tag, " ready_idle"}, 32'(ready_o), 32'd1);
        valid_i = 1'b1; memren_i = v.ren; memwen_i = v.wen; funct3_i = v.f3;
        addr_i = v.addr; wdata_i = v.wdata; ready_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        chk({tag, " req"}, 32'(dmem_req_o), 32'(v.e_req));
        chk({tag, " ready_busy"}, 32'(ready_o), 32'd0);
        if (v.e_req) begin
            chk({tag, " addr"}, dmem_addr_o, v.e_addr);
            chk({tag, " we"}, 32'(dmem_we_o), 32'(v.e_we));
            if (v.e_we) begin
                chk({tag, " be"}, 32'(dmem_be_o), 32'(v.e_be));
                chk({tag, " wdata"}, dmem_wdata_o, v.e_wdata);
            end
            chk({tag, " valid_early"}, 32'(valid_o), 32'd0);
            repeat (v.ack_dly) @(negedge clk);
            chk({tag, " req_held"}, 32'(dmem_req_o), 32'd1);
            chk({tag, " addr_held"}, dmem_addr_o, v.e_addr);
            dmem_ack_i = 1'b1; dmem_rdata_i = v.rdata;
            @(negedge clk);
            dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
            chk({tag, " req_drop"}, 32'(dmem_req_o), 32'd0);
            chk({tag, " be_drop"}, 32'(dmem_be_o), 32'd0);
            chk({tag, " we_drop"}, 32'(dmem_we_o), 32'd0);
        end
        chk({tag, " valid"}, 32'(valid_o), 32'd1);
        chk({tag, " error"}, 32'(error_o), 32'(v.e_err));
        chk({tag, " data"}, memory_data_o, v.e_data);
        held = memory_data_o;
        // A legal load offered while busy must not be captured.
        valid_i = 1'b1; memren_i = 1'b1; memwen_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0100;
        repeat (v.rdy_dly) @(negedge clk);
        if (v.rdy_dly > 0) begin
            chk({tag, " valid_hold"}, 32'(valid_o), 32'd1);
            chk({tag, " data_hold"}, memory_data_o, held);
            chk({tag, " ready_hold"}, 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0; valid_i = 1'b0; memren_i = 1'b0;
        chk({tag, " valid_done"}, 32'(valid_o), 32'd0);
        chk({tag, " ready_done"}, 32'(ready_o), 32'd1);
        chk({tag, " no_capture"}, 32'(dmem_req_o), 32'd0);
    endtask

    vec_t tbl[8];

    initial begin
        vec_t v;
        int   r;
        tbl[0] = '{1'b1, 1'b0, 3'b000, 32'h1000_0003, 32'h0, 32'h80FF_0000, 2, 0,
                   1'b0, 1'b1, 1'b0, 4'b1000, 32'h0, 32'h1000_0000, 32'hFFFF_FF80};
        tbl[1] = '{1'b0, 1'b1, 3'b001, 32'h2000_0002, 32'h1234_ABCD, 32'hDEAD_BEEF, 1, 0,
                   1'b0, 1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h2000_0000, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 3'b010, 32'h3000_0001, 32'h0, 32'h0, 0, 0,
                   1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 3'b101, 32'h4000_0002, 32'h0, 32'hBEEF_1234, 0, 3,
                   1'b0, 1'b1, 1'b0, 4'b1100, 32'h0, 32'h4000_0000, 32'h0000_BEEF};
        tbl[4] = '{1'b0, 1'b0, 3'b000, 32'h0000_0005, 32'h0, 32'h0, 0, 1,
                   1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 0, 0,
                   1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0};
        tbl[6] = '{1'b0, 1'b1, 3'b000, 32'h5000_0001, 32'h0000_00A5, 32'h0, 0, 0,
                   1'b0, 1'b1, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h5000_0000, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 3'b001, 32'h6000_0002, 32'h0, 32'h8001_0000, 1, 0,
                   1'b0, 1'b1, 1'b0, 4'b1100, 32'h0, 32'h6000_0000, 32'hFFFF_8001};

        #12;
        chk("rst ready", 32'(ready_o), 32'd1);
        chk("rst valid", 32'(valid_o), 32'd0);
        chk("rst req", 32'(dmem_req_o), 32'd0);
        chk("rst addr", dmem_addr_o, 32'h0);
        chk("rst data", memory_data_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray ack while idle must not produce a result.
        @(negedge clk);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("idle_ack valid", 32'(valid_o), 32'd0);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            v.ren = (r < 5); v.wen = (r >= 4 && r < 9);
            if ($urandom_range(0, 3) == 0) v.f3 = 3'($urandom_range(0, 7));
            else if (v.wen) v.f3 = 3'($urandom_range(0, 2));
            else v.f3 = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2));
            v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
            v.ack_dly = $urandom_range(0, 3); v.rdy_dly = $urandom_range(0, 2);
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        // Reset while a load is outstanding, then a late ack.
        @(negedge clk);
        valid_i = 1'b1; memren_i = 1'b1; memwen_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0010;
        @(negedge clk);
        valid_i = 1'b0; memren_i = 1'b0;
        chk("mid_req req", 32'(dmem_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_req rst req", 32'(dmem_req_o), 32'd0);
        chk("mid_req rst ready", 32'(ready_o), 32'd1);
        chk("mid_req rst addr", dmem_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        chk("late_ack valid", 32'(valid_o), 32'd0);
        chk("late_ack ready", 32'(ready_o), 32'd1);
        chk("late_ack req", 32'(dmem_req_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
